// File: rtl/pill_feeder_sim.sv
// Plant-side model of the pill hopper, chute and bottle conveyor.
// Emits one-cycle pill pulses while the bottling controller runs, tracks the
// hopper fill level, indexes a fresh bottle after each bottle_full pulse and
// reports starvation, stop and emergency conditions.
//
// Pulse interface: pill_pulse is a registered, one-cycle strobe with no
// back-pressure. The receiver must count every cycle in which it is high.
// Two consecutive high cycles never occur.
module pill_feeder_sim #(
    parameter int PILL_PERIOD   = 100,
    parameter int INDEX_TICKS   = 500,
    parameter int HOPPER_MAX    = 999,
    parameter int HOPPER_REFILL = 200,
    parameter int LEVEL_W       = 10
) (
    input  logic               clk_1khz,
    input  logic               clr,
    input  logic               run,
    input  logic               bottle_full,
    input  logic               hopper_add,
    input  logic               hopper_stop,
    input  logic               conveyor_stop,
    input  logic               emergncy_stop,
    output logic               pill_pulse,
    output logic               bottle_ready,
    output logic [LEVEL_W-1:0] hopper_level,
    output logic [2:0]         feeder_state,
    output logic               fault
);

    localparam int PW = (PILL_PERIOD > 1) ? $clog2(PILL_PERIOD) : 1;
    localparam int IW = (INDEX_TICKS > 1) ? $clog2(INDEX_TICKS) : 1;

    localparam logic [PW-1:0]      PERIOD_LAST = PW'(PILL_PERIOD - 1);
    localparam logic [IW-1:0]      INDEX_LAST  = IW'(INDEX_TICKS - 1);
    localparam logic [LEVEL_W:0]   LEVEL_CAP   = (LEVEL_W+1)'(HOPPER_MAX);
    localparam logic [LEVEL_W:0]   REFILL_AMT  = (LEVEL_W+1)'(HOPPER_REFILL);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_INDEX   = 3'd2,
        S_STARVED = 3'd3,
        S_HALT    = 3'd4
    } feeder_state_t;

    feeder_state_t      state_q, state_d;
    logic [PW-1:0]      period_q, period_d;
    logic [IW-1:0]      index_q, index_d;
    logic [LEVEL_W-1:0] level_d;
    logic [LEVEL_W-1:0] level_after_pill;
    logic [LEVEL_W:0]   level_sum;
    logic               add_q;
    logic               add_edge;
    logic               emit;

    // Next-state, counter updates and pill emission decision.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        index_d  = index_q;
        emit     = 1'b0;

        if (emergncy_stop) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_d  = S_FEED;
                        period_d = '0;
                    end
                end
                S_FEED: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end else if (bottle_full) begin
                        // A due pill is dropped on the floor: the chute closes
                        // as soon as the bottle is declared full.
                        state_d  = S_INDEX;
                        index_d  = '0;
                        period_d = '0;
                    end else if (hopper_level == '0) begin
                        state_d = S_STARVED;
                    end else if (!hopper_stop) begin
                        if (period_q == PERIOD_LAST) begin
                            emit     = 1'b1;
                            period_d = '0;
                        end else begin
                            period_d = period_q + 1'b1;
                        end
                    end
                end
                S_INDEX: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end else if (!conveyor_stop) begin
                        if (index_q == INDEX_LAST) begin
                            state_d  = S_FEED;
                            period_d = '0;
                        end else begin
                            index_d = index_q + 1'b1;
                        end
                    end
                end
                S_STARVED: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end else if (hopper_level != '0) begin
                        state_d  = S_FEED;
                        period_d = '0;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Hopper level: subtract an emitted pill, then apply a saturating refill.
    always_comb begin
        add_edge         = hopper_add & ~add_q;
        level_after_pill = hopper_level - LEVEL_W'(emit);
        level_sum        = {1'b0, level_after_pill} + REFILL_AMT;
        level_d          = level_after_pill;
        if (add_edge) begin
            if (level_sum > LEVEL_CAP) begin
                level_d = LEVEL_CAP[LEVEL_W-1:0];
            end else begin
                level_d = level_sum[LEVEL_W-1:0];
            end
        end
    end

    // State, counters, level, refill edge register and registered pulse.
    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            state_q      <= S_IDLE;
            period_q     <= '0;
            index_q      <= '0;
            hopper_level <= LEVEL_CAP[LEVEL_W-1:0];
            add_q        <= 1'b0;
            pill_pulse   <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            index_q      <= index_d;
            hopper_level <= level_d;
            add_q        <= hopper_add;
            pill_pulse   <= emit;
        end
    end

    // Status outputs decoded directly from the state register.
    always_comb begin
        feeder_state = state_q;
        bottle_ready = (state_q == S_FEED) || (state_q == S_STARVED);
        fault        = (state_q == S_STARVED);
    end

endmodule

// File: tb/tb_pill_feeder_sim.sv
// Bench for pill_feeder_sim: directed scenarios followed by random stimulus,
// each cycle checked against a countdown-based behavioural model.
module tb_pill_feeder_sim;

    localparam int PILL_PERIOD   = 4;
    localparam int INDEX_TICKS   = 6;
    localparam int HOPPER_MAX    = 999;
    localparam int HOPPER_REFILL = 200;
    localparam int LEVEL_W       = 10;
    localparam int W             = 16;

    localparam int M_IDLE = 0, M_FEED = 1, M_INDEX = 2, M_STARVED = 3, M_HALT = 4;

    // clock / reset block
    logic clk_1khz;
    logic clr, run, bottle_full, hopper_add, hopper_stop, conveyor_stop, emergncy_stop;
    logic               pill_pulse, bottle_ready, fault;
    logic [LEVEL_W-1:0] hopper_level;
    logic [2:0]         feeder_state;

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    pill_feeder_sim #(
        .PILL_PERIOD  (PILL_PERIOD),
        .INDEX_TICKS  (INDEX_TICKS),
        .HOPPER_MAX   (HOPPER_MAX),
        .HOPPER_REFILL(HOPPER_REFILL),
        .LEVEL_W      (LEVEL_W)
    ) dut (
        .clk_1khz     (clk_1khz),
        .clr          (clr),
        .run          (run),
        .bottle_full  (bottle_full),
        .hopper_add   (hopper_add),
        .hopper_stop  (hopper_stop),
        .conveyor_stop(conveyor_stop),
        .emergncy_stop(emergncy_stop),
        .pill_pulse   (pill_pulse),
        .bottle_ready (bottle_ready),
        .hopper_level (hopper_level),
        .feeder_state (feeder_state),
        .fault        (fault)
    );

    int tests_run = 0;
    int tests_failed = 0;

    logic [W-1:0]       exp_q[$];
    logic [LEVEL_W-1:0] pulse_q[$];

    // behavioural model: countdowns to the next pill / end of conveyor motion
    int m_state    = M_IDLE;
    int m_due      = PILL_PERIOD;
    int m_left     = INDEX_TICKS;
    int m_level    = HOPPER_MAX;
    bit m_add_prev = 1'b0;
    bit m_pulse    = 1'b0;

    task automatic model_step();
        bit emit;
        emit = 1'b0;
        if (clr) begin
            m_state    = M_IDLE;
            m_level    = HOPPER_MAX;
            m_add_prev = 1'b0;
            m_pulse    = 1'b0;
            return;
        end
        if (emergncy_stop) begin
            m_state = M_HALT;
        end else begin
            case (m_state)
                M_HALT: if (!run) m_state = M_IDLE;
                M_IDLE: if (run) begin m_state = M_FEED; m_due = PILL_PERIOD; end
                M_FEED: begin
                    if (!run) m_state = M_IDLE;
                    else if (bottle_full) begin m_state = M_INDEX; m_left = INDEX_TICKS; end
                    else if (m_level == 0) m_state = M_STARVED;
                    else if (!hopper_stop) begin
                        m_due = m_due - 1;
                        if (m_due == 0) begin emit = 1'b1; m_due = PILL_PERIOD; end
                    end
                end
                M_INDEX: begin
                    if (!run) m_state = M_IDLE;
                    else if (!conveyor_stop) begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin m_state = M_FEED; m_due = PILL_PERIOD; end
                    end
                end
                M_STARVED: begin
                    if (!run) m_state = M_IDLE;
                    else if (m_level > 0) begin m_state = M_FEED; m_due = PILL_PERIOD; end
                end
                default: m_state = M_IDLE;
            endcase
        end
        if (emit) m_level = m_level - 1;
        if (hopper_add && !m_add_prev) begin
            m_level = m_level + HOPPER_REFILL;
            if (m_level > HOPPER_MAX) m_level = HOPPER_MAX;
        end
        m_add_prev = hopper_add;
        m_pulse    = emit;
        if (emit) pulse_q.push_back(LEVEL_W'(m_level));
    endtask

    function automatic logic [W-1:0] model_vec();
        logic ready_e, fault_e;
        ready_e = (m_state == M_FEED) || (m_state == M_STARVED);
        fault_e = (m_state == M_STARVED);
        return {m_pulse, ready_e, fault_e, 3'(m_state), LEVEL_W'(m_level)};
    endfunction

    function automatic bit pill_pending();
        return (m_state == M_FEED) && (m_level != 0) && (m_due == 1);
    endfunction

    // driver tasks: inputs are set before calling cycle(); it predicts the
    // post-edge outputs and returns at the following negedge
    task automatic cycle();
        model_step();
        exp_q.push_back(model_vec());
        @(negedge clk_1khz);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor: one output vector per clock edge, plus per-pulse level
    initial begin
        logic [W-1:0] exp_v, got_v;
        logic [LEVEL_W-1:0] exp_l;
        forever begin
            @(posedge clk_1khz);
            #1;
            got_v = {pill_pulse, bottle_ready, fault, feeder_state, hopper_level};
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL scoreboard_underflow: got %h expected none", got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    tests_failed++;
                    $display("FAIL outputs: got pulse=%0b ready=%0b fault=%0b state=%0d level=%0d expected pulse=%0b ready=%0b fault=%0b state=%0d level=%0d",
                             got_v[15], got_v[14], got_v[13], got_v[12:10], got_v[9:0],
                             exp_v[15], exp_v[14], exp_v[13], exp_v[12:10], exp_v[9:0]);
                end
            end
            if (pill_pulse === 1'b1) begin
                tests_run++;
                if (pulse_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_pulse: got level=%0d expected no pulse", hopper_level);
                end else begin
                    exp_l = pulse_q.pop_front();
                    if (hopper_level !== exp_l) begin
                        tests_failed++;
                        $display("FAIL pulse_level: got %0d expected %0d", hopper_level, exp_l);
                    end
                end
            end
        end
    end

    task automatic wait_pill_pending(input string name);
        int n;
        n = 0;
        while (!pill_pending() && n < 50) begin cycle(); n++; end
        check({name, "_pending_bound"}, int'(pill_pending()), 1);
    endtask

    task automatic measure_index(input string name, input bit with_stall, input int exp_cycles);
        int n;
        wait_pill_pending(name);
        bottle_full = 1'b1;
        cycle();
        bottle_full = 1'b0;
        check({name, "_state"}, int'(feeder_state), M_INDEX);
        check({name, "_no_pulse"}, int'(pill_pulse), 0);
        check({name, "_ready"}, int'(bottle_ready), 0);
        n = 0;
        while (feeder_state == 3'(M_INDEX) && n < 50) begin
            n++;
            bottle_full   = (n == 2);
            conveyor_stop = with_stall && (n >= 2) && (n < 5);
            cycle();
        end
        bottle_full   = 1'b0;
        conveyor_stop = 1'b0;
        check({name, "_cycles"}, n, exp_cycles);
        check({name, "_back_to_feed"}, int'(feeder_state), M_FEED);
    endtask

    initial begin
        int n;
        clr = 1'b1; run = 1'b0; bottle_full = 1'b0; hopper_add = 1'b0;
        hopper_stop = 1'b0; conveyor_stop = 1'b0; emergncy_stop = 1'b0;
        cycle();
        cycle();
        check("reset_state", int'(feeder_state), M_IDLE);
        check("reset_level", int'(hopper_level), HOPPER_MAX);
        check("reset_pulse", int'(pill_pulse), 0);
        check("reset_ready", int'(bottle_ready), 0);
        check("reset_fault", int'(fault), 0);

        // pulse rate, hopper_stop freeze, saturating refill
        clr = 1'b0; run = 1'b1;
        cycle();
        check("enter_feed", int'(feeder_state), M_FEED);
        repeat (8) cycle();
        check("level_after_2", int'(hopper_level), 997);
        hopper_stop = 1'b1;
        repeat (10) cycle();
        hopper_stop = 1'b0;
        check("level_frozen", int'(hopper_level), 997);
        repeat (8) cycle();
        check("level_after_4", int'(hopper_level), 995);
        hopper_add = 1'b1;
        cycle();
        check("refill_saturate", int'(hopper_level), HOPPER_MAX);
        hopper_add = 1'b0;
        cycle();

        // bottle change, with and without a conveyor stall
        measure_index("index", 1'b0, INDEX_TICKS);
        measure_index("index_stall", 1'b1, INDEX_TICKS + 3);

        // emergency stop
        repeat (3) cycle();
        emergncy_stop = 1'b1;
        cycle();
        check("estop_state", int'(feeder_state), M_HALT);
        check("estop_pulse", int'(pill_pulse), 0);
        repeat (5) cycle();
        emergncy_stop = 1'b0;
        repeat (3) cycle();
        check("halt_held_run", int'(feeder_state), M_HALT);
        run = 1'b0;
        cycle();
        check("halt_release", int'(feeder_state), M_IDLE);

        // clr in the middle of a bottle change
        run = 1'b1;
        repeat (3) cycle();
        bottle_full = 1'b1;
        cycle();
        bottle_full = 1'b0;
        cycle();
        check("pre_clr_index", int'(feeder_state), M_INDEX);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check("clr_state", int'(feeder_state), M_IDLE);
        check("clr_level", int'(hopper_level), HOPPER_MAX);
        check("clr_pulse", int'(pill_pulse), 0);
        cycle();
        check("clr_refeed", int'(feeder_state), M_FEED);

        // drain the hopper to starvation, then refill
        n = 0;
        while (fault !== 1'b1 && n < 6000) begin cycle(); n++; end
        check("starve_reached", int'(fault), 1);
        check("starve_state", int'(feeder_state), M_STARVED);
        check("starve_level", int'(hopper_level), 0);
        check("starve_ready", int'(bottle_ready), 1);
        hopper_add = 1'b1;
        cycle();
        check("refill_from_empty", int'(hopper_level), HOPPER_REFILL);
        hopper_add = 1'b0;
        cycle();
        check("starve_resume", int'(feeder_state), M_FEED);
        check("starve_fault_clear", int'(fault), 0);

        // refill landing on the same edge as a pill at level 10
        n = 0;
        while (!(pill_pending() && m_level == 10) && n < 2000) begin cycle(); n++; end
        check("level10_reached", int'(hopper_level), 10);
        hopper_add = 1'b1;
        cycle();
        hopper_add = 1'b0;
        check("pill_plus_refill", int'(hopper_level), 10 - 1 + HOPPER_REFILL);
        check("pill_plus_refill_pulse", int'(pill_pulse), 1);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) emergncy_stop = ~emergncy_stop;
            if ($urandom_range(0, 39) == 0)  run = ~run;
            if ($urandom_range(0, 14) == 0)  hopper_stop = ~hopper_stop;
            if ($urandom_range(0, 9) == 0)   conveyor_stop = ~conveyor_stop;
            if ($urandom_range(0, 19) == 0)  hopper_add = ~hopper_add;
            bottle_full = ($urandom_range(0, 29) == 0);
            cycle();
        end
        clr = 1'b0; emergncy_stop = 1'b0; bottle_full = 1'b0;
        repeat (2) cycle();
        check("exp_q_drained", exp_q.size(), 0);
        check("pulse_q_drained", pulse_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pill_feeder_sim.md
Name: pill_feeder_sim

Overview:
- Plant-side model of the hopper, chute and conveyor: the transmitting end of the pill-pulse interface that the bottling controller counts.
- While the controller is running, emits one-cycle pill pulses at a fixed rate.
- Tracks hopper contents and indexes a fresh bottle under the chute after each bottle-full pulse.
- Reports hopper-empty, stop and emergency conditions back to the controller and to the displays.

Parameters:
PILL_PERIOD, 100, clk_1khz cycles between pills (10 pills/s)
INDEX_TICKS, 500, clk_1khz cycles of conveyor motion per bottle change
HOPPER_MAX, 999, hopper capacity in pills; also the reset fill level
HOPPER_REFILL, 200, pills added per hopper_add press
LEVEL_W, 10, width of hopper_level; must hold HOPPER_MAX

Ports:
clk_1khz  in  1  system clock, 1 kHz
clr  in  1  synchronous reset, active-high
run  in  1  level; high while the controller is in RUNNING
bottle_full  in  1  one-cycle pulse from the controller when the current bottle reaches its target
hopper_add  in  1  level from switch; each rising edge refills
hopper_stop  in  1  level; freezes dispensing
conveyor_stop  in  1  level; freezes conveyor indexing
emergncy_stop  in  1  level; immediate halt
pill_pulse  out  1  one-cycle pulse per pill dropped
bottle_ready  out  1  bottle in place under chute
hopper_level  out  LEVEL_W  pills remaining, binary
feeder_state  out  3  current state code, for display
fault  out  1  hopper empty while feeding

Behaviour:
- One clock (clk_1khz). Reset is synchronous and active-high (clr). All state changes happen on the rising edge of clk_1khz.
- clr has top priority. On reset:
  - state=IDLE, pill_pulse=0, hopper_level=HOPPER_MAX, fault=0, bottle_ready=0.
  - Period and index counters are cleared to 0; the hopper_add edge register is cleared to 0.
- clr asserted mid-operation (any state) → reset values on the next edge; no partial pulse.
- State codes: IDLE=0, FEED=1, INDEX=2, STARVED=3, HALT=4. feeder_state is the state register.
- emergncy_stop=1 in any state → HALT on the next edge. This overrides every other transition, and pill_pulse is 0 from that edge on.
- HALT → IDLE only when emergncy_stop=0 and run=0. If emergncy_stop is released while run=1, stay in HALT.
- IDLE:
  - run=1 → FEED; period counter cleared.
- FEED:
  - Transition priority: run=0 → IDLE; else bottle_full=1 → INDEX, with index counter=0, period counter=0 and no pulse that cycle; else hopper_level==0 → STARVED.
  - Otherwise, with hopper_stop=0: if period counter==PILL_PERIOD-1, then pill_pulse←1, hopper_level decrements, period counter←0; else period counter increments and pill_pulse←0.
  - With hopper_stop=1: period counter holds and pill_pulse←0.
  - First pulse appears PILL_PERIOD cycles after entering FEED. Pulses are PILL_PERIOD cycles apart.
- INDEX:
  - run=0 → IDLE.
  - Index counter increments only while conveyor_stop=0.
  - When the counter equals INDEX_TICKS-1 with conveyor_stop=0 → FEED with the period counter cleared.
  - bottle_full pulses received in INDEX are ignored.
- STARVED:
  - run=0 → IDLE; else hopper_level>0 → FEED with the period counter cleared.
- pill_pulse:
  - Registered; never high for two consecutive cycles.
  - Never high outside the cycle following a FEED-state emission.
- bottle_ready = 1 in FEED and STARVED, 0 in all other states. Decoded from the state register.
- fault = 1 exactly while state==STARVED.
- Refill:
  - hopper_add is edge-detected against the previous-cycle sample. A rising edge adds HOPPER_REFILL, saturating at HOPPER_MAX.
  - Refill is accepted in every state, including HALT.
- Same-cycle pill and refill: hopper_level ← min(level − 1 + HOPPER_REFILL, HOPPER_MAX).
- hopper_level never underflows, because no emission occurs at level 0.

Test Plan:
1. Bench PILL_PERIOD=4. clr, then run=1 → first pill_pulse 4 cycles after FEED entry, then every 4 cycles. hopper_level goes 999, 998, 997. Holding hopper_stop=1 for 10 cycles delays the next pulse by exactly 10 cycles.
2. Bench INDEX_TICKS=6. In FEED, pulse bottle_full on a cycle where emission is due → no pulse, state=INDEX, bottle_ready=0 for 6 cycles, then FEED. Repeating with conveyor_stop=1 for 3 cycles mid-INDEX → 9 cycles in INDEX.
3. Bench HOPPER_MAX=3, HOPPER_REFILL=2. Run → 3 pulses, level=0, state=STARVED, fault=1, bottle_ready=1. A hopper_add rising edge → level=2, FEED, fault=0, pulses resume.
4. Mid-FEED, emergncy_stop=1 → feeder_state=4 next edge, pulses stop. Release with run=1 → stays 4. Then run=0 → IDLE (0).
5. At level 995 with HOPPER_REFILL=200 → level saturates at 999. A refill edge in the same cycle as a pill emission at level 10 → level 209.
6. clr asserted mid-INDEX → next edge: state=IDLE, level=HOPPER_MAX, pill_pulse=0, counters 0. With run still high → FEED the following edge.
